pc_predict: RTL
===============

// Module: pc_predict
// PURPOSE
//  Next-generation fetch PC register with a parametrised direct-mapped branch target buffer (BTB)
//  and 2-bit saturating predictors. Sits at the head of the fetch stage and drives imemaddr.
//  Replaces per-source PC muxing: the EX stage resolves control flow and returns redirect/update
//  traffic, while this block speculatively steers fetch on predicted-taken hits.
// PARAMETERS
//  PC_INIT      32'd0  reset fetch address (word aligned)
//  BTB_ENTRIES  16     BTB depth; power of 2, >=2; IDX_W = $clog2(BTB_ENTRIES)
//  CTR_INIT     2'b10  counter value written on allocation (weakly taken)
// PORTS
//  CLK            in   1   clock, all state on posedge
//  RST            in   1   synchronous active-high reset
//  ihit           in   1   imem returned current instruction; PC may advance
//  stall          in   1   pipeline hazard; hold PC even on ihit
//  redirect_en    in   1   EX mispredict / jr / jmp correction
//  redirect_addr  in   32  corrected fetch address
//  upd_en         in   1   EX retires a branch/jump; train BTB
//  upd_pc         in   32  address of the resolved control instruction
//  upd_target     in   32  resolved target
//  upd_taken      in   1   resolved direction
//  imemaddr       out  32  current fetch PC
//  next_imemaddr  out  32  PC to be loaded at next edge (comb)
//  pred_taken     out  1   current PC predicted taken (comb, pipelined to EX by caller)
//  pred_target    out  32  predicted target (valid when pred_taken)
// BEHAVIOUR
//  - One clock CLK; reset is synchronous, active-high on RST, sampled on posedge CLK only.
//  - Reset: imemaddr=PC_INIT; every BTB valid=0, tag=0, target=0, ctr=2'b01; pred_taken=0.
//  - Lookup (comb on imemaddr): idx=pc[IDX_W+1:2], tag=pc[31:IDX_W+2]; hit=valid&&tag match;
//    pred_taken=hit&&ctr[1]; pred_target=entry.target (0 when !hit).
//  - next PC priority: RST -> PC_INIT; redirect_en -> {redirect_addr[31:2],2'b00} regardless of
//    ihit/stall; else (!ihit||stall) -> hold; else pred_taken -> pred_target; else pc+4.
//  - pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0); no flag.
//  - Latency: redirect visible on imemaddr the cycle after assertion; prediction zero-cycle.
//  - Training on upd_en (write at edge), indexed by upd_pc:
//    hit & taken: ctr=sat_inc, target<=upd_target; hit & !taken: ctr=sat_dec, target kept;
//    miss & taken: allocate (valid=1, tag, target, ctr=CTR_INIT), evicting;
//    miss & !taken: no write.
//  - Saturation: 2'b11 stays 2'b11 on taken; 2'b00 stays 2'b00 on not-taken.
//  - Lookup and update same index same cycle: lookup sees pre-edge contents (no bypass).
//  - redirect_en and upd_en same cycle: independent; both take effect.
//  - RST asserted with upd_en: reset wins; no training write.
//  - RST mid-stall/mid-redirect: all pending state discarded; fetch restarts at PC_INIT.
//  - upd_target/redirect_addr low 2 bits ignored (forced 00).
// STRUCTURE
//  - Package pc_predict_pkg (imports cpu_types_pkg word_t): typedef btb_entry_t struct
//    {valid, tag, target[31:2]}; typedef logic[1:0] pred_ctr_t; constants CTR_SNT=2'b00,
//    CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
//  - Sub-module btb_table: entry array + counters, one comb read port, one sync write port,
//    sync reset; parametrised by BTB_ENTRIES. pc_predict holds PC register and next-PC priority.
// TESTING
//  1 Reset: RST=1 two cycles, PC_INIT=32'h200 -> imemaddr=32'h200, pred_taken=0; RST=0, ihit=1
//    -> 32'h204, 32'h208 sequentially.
//  2 Hold: ihit=0 or stall=1 at pc=32'h10 for 3 cycles -> imemaddr stays 32'h10; redirect_en
//    with redirect_addr=32'h43 during stall -> next cycle imemaddr=32'h40.
//  3 Allocate/predict: upd_en, upd_pc=32'h100, upd_target=32'h180, taken; later fetch of 32'h100
//    with ihit -> pred_taken=1, next imemaddr=32'h180.
//  4 Counter: from CTR_INIT, two not-taken updates for 32'h100 -> ctr=00, fetch of 32'h100 goes
//    to 32'h104; three taken -> ctr=11, fourth taken keeps 11.
//  5 Alias/evict (BTB_ENTRIES=16): entry for 32'h100, then taken update at 32'h140 (same idx)
//    -> 32'h100 now misses (pc+4), 32'h140 hits; not-taken miss at 32'h180 -> no change.
//  6 Wrap & collision: pc=32'hFFFF_FFFC, ihit -> 0; upd_en on index being fetched same cycle
//    -> current pred uses old entry, new entry seen next lookup.

Source files
------------

// File: rtl/pc_predict_pkg.sv
// Shared types and constants for the fetch PC predictor and its BTB.
package pc_predict_pkg;

    typedef logic [31:0] word_t;
    typedef logic [1:0]  pred_ctr_t;

    localparam pred_ctr_t CTR_SNT = 2'b00;
    localparam pred_ctr_t CTR_WNT = 2'b01;
    localparam pred_ctr_t CTR_WT  = 2'b10;
    localparam pred_ctr_t CTR_ST  = 2'b11;

    // tag holds the whole word address (pc[31:2]); the index bits inside it
    // always match for a given slot, so comparing them is harmless and keeps
    // the struct independent of BTB depth.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [29:0] target;
    } btb_entry_t;

    // Two-bit saturating counter step.
    function automatic pred_ctr_t ctr_step(pred_ctr_t c, logic taken);
        pred_ctr_t r;
        r = c;
        if (taken && c != CTR_ST)
            r = c + 2'd1;
        else if (!taken && c != CTR_SNT)
            r = c - 2'd1;
        return r;
    endfunction

endpackage

// File: rtl/pc_predict_if.sv
// Fetch-side bus: pipeline control and EX feedback in, fetch PC and prediction out.
interface pc_predict_if;
    import pc_predict_pkg::*;

    logic  ihit;
    logic  stall;
    logic  redirect_en;
    word_t redirect_addr;
    logic  upd_en;
    word_t upd_pc;
    word_t upd_target;
    logic  upd_taken;
    word_t imemaddr;
    word_t next_imemaddr;
    logic  pred_taken;
    word_t pred_target;

    modport master (
        output ihit, stall, redirect_en, redirect_addr,
        output upd_en, upd_pc, upd_target, upd_taken,
        input  imemaddr, next_imemaddr, pred_taken, pred_target
    );

    modport slave (
        input  ihit, stall, redirect_en, redirect_addr,
        input  upd_en, upd_pc, upd_target, upd_taken,
        output imemaddr, next_imemaddr, pred_taken, pred_target
    );

endinterface

// File: rtl/pc_predict_btb_table.sv
// Direct-mapped BTB: entry array plus 2-bit counters, one combinational read
// port and one synchronous training port. Addresses are word addresses (pc[31:2]).
module btb_table
    import pc_predict_pkg::*;
#(
    parameter int        BTB_ENTRIES = 16,
    parameter pred_ctr_t CTR_INIT    = CTR_WT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [29:0] rd_wa_i,
    output logic        rd_hit_o,
    output pred_ctr_t   rd_ctr_o,
    output logic [29:0] rd_target_o,
    input  logic        wr_en_i,
    input  logic [29:0] wr_wa_i,
    input  logic [29:0] wr_target_i,
    input  logic        wr_taken_i
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);

    btb_entry_t ent_q [BTB_ENTRIES];
    pred_ctr_t  ctr_q [BTB_ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_hit;

    assign rd_idx = rd_wa_i[IDX_W-1:0];
    assign wr_idx = wr_wa_i[IDX_W-1:0];

    // Read port: plain array read, so a same-cycle write is not visible until after the edge.
    always_comb begin
        rd_hit_o    = ent_q[rd_idx].valid && (ent_q[rd_idx].tag == rd_wa_i);
        rd_ctr_o    = ctr_q[rd_idx];
        rd_target_o = rd_hit_o ? ent_q[rd_idx].target : '0;
    end

    assign wr_hit = ent_q[wr_idx].valid && (ent_q[wr_idx].tag == wr_wa_i);

    // Training: hits adjust the counter (taken also refreshes target), taken misses
    // allocate over whatever was in the slot, not-taken misses leave the table alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                ent_q[i] <= '0;
                ctr_q[i] <= CTR_WNT;
            end
        end else if (wr_en_i) begin
            if (wr_hit) begin
                ctr_q[wr_idx] <= ctr_step(ctr_q[wr_idx], wr_taken_i);
                if (wr_taken_i)
                    ent_q[wr_idx].target <= wr_target_i;
            end else if (wr_taken_i) begin
                ent_q[wr_idx] <= '{valid: 1'b1, tag: wr_wa_i, target: wr_target_i};
                ctr_q[wr_idx] <= CTR_INIT;
            end
        end
    end

endmodule

// File: rtl/pc_predict.sv
// Fetch PC register with next-PC priority and BTB-based zero-cycle prediction.
module pc_predict
    import pc_predict_pkg::*;
#(
    parameter word_t     PC_INIT     = 32'd0,
    parameter int        BTB_ENTRIES = 16,
    parameter pred_ctr_t CTR_INIT    = CTR_WT
) (
    input  logic        CLK,
    input  logic        RST,
    pc_predict_if.slave bus
);

    word_t       pc_q;
    word_t       pc_d;
    logic        btb_hit;
    pred_ctr_t   btb_ctr;
    logic [29:0] btb_tgt;
    logic        pred_taken;
    word_t       pred_target;

    btb_table #(
        .BTB_ENTRIES (BTB_ENTRIES),
        .CTR_INIT    (CTR_INIT)
    ) u_btb (
        .clk_i       (CLK),
        .rst_i       (RST),
        .rd_wa_i     (pc_q[31:2]),
        .rd_hit_o    (btb_hit),
        .rd_ctr_o    (btb_ctr),
        .rd_target_o (btb_tgt),
        .wr_en_i     (bus.upd_en),
        .wr_wa_i     (bus.upd_pc[31:2]),
        .wr_target_i (bus.upd_target[31:2]),
        .wr_taken_i  (bus.upd_taken)
    );

    assign pred_taken  = btb_hit && btb_ctr[1];
    assign pred_target = {btb_tgt, 2'b00};

    // Next fetch PC: reset, then EX redirect (overrides hold), then hold, then prediction, then sequential.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (RST)
            pc_d = PC_INIT;
        else if (bus.redirect_en)
            pc_d = {bus.redirect_addr[31:2], 2'b00};
        else if (!bus.ihit || bus.stall)
            pc_d = pc_q;
        else if (pred_taken)
            pc_d = pred_target;
    end

    // Fetch PC register.
    always_ff @(posedge CLK) begin
        if (RST)
            pc_q <= PC_INIT;
        else
            pc_q <= pc_d;
    end

    assign bus.imemaddr      = pc_q;
    assign bus.next_imemaddr = pc_d;
    assign bus.pred_taken    = pred_taken;
    assign bus.pred_target   = pred_target;

    // Byte-offset bits of incoming addresses are deliberately dropped.
    logic unused_lsbs;
    assign unused_lsbs = ^{bus.redirect_addr[1:0], bus.upd_pc[1:0], bus.upd_target[1:0]};

endmodule
